// File: rtl/ms_decade_code_counter.sv
// Millisecond counter: prescaler, BCD decade chain and a registered,
// runtime-selectable weighted-code output with hold/lap support.
module ms_decade_code_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  hold,
  input  logic [1:0]            mode,
  output logic [4*DIGITS-1:0]   code_out,
  output logic                  tick_ms,
  output logic                  overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] M_8421 = 2'b00;
  localparam logic [1:0] M_5421 = 2'b01;
  localparam logic [1:0] M_2421 = 2'b10;
  localparam logic [1:0] M_XS3  = 2'b11;

  logic [PW-1:0]        pre_q, pre_d;
  logic [4*DIGITS-1:0]  dig_q, dig_d;
  logic [4*DIGITS-1:0]  enc;
  logic [4*DIGITS-1:0]  code_q, code_d;
  logic                 tick_q, tick_d;
  logic                 ovf_q, ovf_d;
  logic                 term;
  logic                 carry;

  function automatic logic [3:0] encode(
    input logic [3:0] d,
    input logic [1:0] m
  );
    logic [3:0] r;
    r = d;
    case (m)
      M_8421: r = d;
      M_5421: if (d >= 4'd5) r = d + 4'd3;
      M_2421: if (d >= 4'd5) r = d + 4'd6;
      M_XS3:  r = d + 4'd3;
      default: r = d;
    endcase
    return r;
  endfunction

  assign term = en && (pre_q == PMAX);

  always_comb begin
    pre_d = pre_q;
    if (clr)
      pre_d = '0;
    else if (en)
      pre_d = term ? '0 : pre_q + 1'b1;
  end

  // Ripple carry: a digit advances only when every lower digit is at 9.
  always_comb begin
    logic [3:0] d;
    dig_d = dig_q;
    carry = term;
    for (int k = 0; k < DIGITS; k++) begin
      d = dig_q[4*k +: 4];
      if (carry)
        dig_d[4*k +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
      carry = carry && (d == 4'd9);
    end
    if (clr)
      dig_d = '0;
  end

  assign tick_d = term && !clr;
  assign ovf_d  = carry && !clr;

  always_comb begin
    enc = '0;
    for (int k = 0; k < DIGITS; k++)
      enc[4*k +: 4] = encode(dig_q[4*k +: 4], mode);
  end

  assign code_d = hold ? code_q : enc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      dig_q  <= '0;
      code_q <= '0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      dig_q  <= dig_d;
      code_q <= code_d;
      tick_q <= tick_d;
      ovf_q  <= ovf_d;
    end
  end

  assign code_out = code_q;
  assign tick_ms  = tick_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ms_decade_code_counter.sv
// Bench for ms_decade_code_counter: behavioural model on integer counts,
// per-cycle compare, directed scenarios plus randomized traffic.
module tb_ms_decade_code_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic       hold;
  logic [1:0] mode;
  logic [7:0] code_out;
  logic       tick_ms;
  logic       overflow;

  int total;
  int passed;

  int         m_cnt;
  int         m_pre;
  logic [7:0] m_code;
  logic       m_tick;
  logic       m_ovf;

  ms_decade_code_counter #(
    .DIGITS   (2),
    .TICK_DIV (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .hold     (hold),
    .mode     (mode),
    .code_out (code_out),
    .tick_ms  (tick_ms),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] enc(input int c, input logic [1:0] m);
    int d;
    int e;
    int r;
    int w;
    r = 0;
    w = 1;
    for (int k = 0; k < 2; k++) begin
      d = (c / w) % 10;
      case (m)
        2'd0: e = d;
        2'd1: e = (d >= 5) ? d + 3 : d;
        2'd2: e = (d >= 5) ? d + 6 : d;
        default: e = d + 3;
      endcase
      r = r + (e << (4 * k));
      w = w * 10;
    end
    return 8'(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: plain integer count and prescaler phase.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  = 0;
      m_pre  = 0;
      m_code = 8'h00;
      m_tick = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_code = hold ? m_code : enc(m_cnt, mode);
      m_tick = 1'b0;
      m_ovf  = 1'b0;
      if (clr) begin
        m_cnt = 0;
        m_pre = 0;
      end else if (en) begin
        if (m_pre == 3) begin
          m_pre  = 0;
          m_tick = 1'b1;
          m_ovf  = (m_cnt == 99);
          m_cnt  = (m_cnt + 1) % 100;
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("code_out", 32'(code_out), 32'(m_code));
    chk("tick_ms",  32'(tick_ms),  32'(m_tick));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic goto(input int n);
    int k;
    k = 0;
    en = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!(m_cnt == n && m_pre == 0) && k < 2000);
    if (k >= 2000) begin
      total++;
      $display("FAIL goto_timeout: count %0d never reached", n);
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst  = 1'b1;
    en   = 1'b0;
    clr  = 1'b0;
    hold = 1'b0;
    mode = 2'b00;
    repeat (2) cyc();
    chk("reset_code", 32'(code_out), 32'h00);
    chk("reset_tick", 32'(tick_ms), 32'h0);

    // First count
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) cyc();
    chk("first_no_tick", 32'(tick_ms), 32'h0);
    chk("first_code0", 32'(code_out), 32'h00);
    cyc();
    chk("first_tick", 32'(tick_ms), 32'h1);
    cyc();
    chk("first_code1", 32'(code_out), 32'h01);
    chk("first_tick_low", 32'(tick_ms), 32'h0);

    // Mode sweep at 57
    goto(57);
    en = 1'b0;
    cyc();
    chk("sweep_8421", 32'(code_out), 32'h57);
    mode = 2'b01;
    cyc();
    chk("sweep_5421", 32'(code_out), 32'h8A);
    mode = 2'b10;
    cyc();
    chk("sweep_2421", 32'(code_out), 32'hBD);
    mode = 2'b11;
    cyc();
    chk("sweep_xs3", 32'(code_out), 32'h8A);
    chk("model_pin_2421", 32'(enc(57, 2'b10)), 32'hBD);

    // Wrap 99 -> 00
    mode = 2'b00;
    goto(99);
    repeat (3) cyc();
    chk("wrap_pre_ovf", 32'(overflow), 32'h0);
    cyc();
    chk("wrap_tick", 32'(tick_ms), 32'h1);
    chk("wrap_ovf", 32'(overflow), 32'h1);
    cyc();
    chk("wrap_code", 32'(code_out), 32'h00);
    chk("wrap_ovf_low", 32'(overflow), 32'h0);

    // Carry 19 -> 20
    goto(19);
    repeat (4) cyc();
    chk("carry_tick", 32'(tick_ms), 32'h1);
    chk("carry_no_ovf", 32'(overflow), 32'h0);
    cyc();
    chk("carry_code", 32'(code_out), 32'h20);

    // Clear in the term cycle at 42
    goto(42);
    repeat (3) cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_no_tick", 32'(tick_ms), 32'h0);
    repeat (3) cyc();
    chk("clr_wait", 32'(tick_ms), 32'h0);
    cyc();
    chk("clr_next_tick", 32'(tick_ms), 32'h1);
    cyc();
    chk("clr_code", 32'(code_out), 32'h01);

    // Hold / lap
    goto(13);
    cyc();
    chk("hold_start", 32'(code_out), 32'h13);
    hold = 1'b1;
    repeat (20) cyc();
    mode = 2'b11;
    repeat (20) cyc();
    chk("hold_frozen", 32'(code_out), 32'h13);
    hold = 1'b0;
    cyc();
    chk("hold_release", 32'(code_out), 32'h56);

    // Async reset at 68, pre=2
    goto(68);
    repeat (2) cyc();
    #1 rst = 1'b1;
    #1;
    chk("areset_code", 32'(code_out), 32'h00);
    chk("areset_tick", 32'(tick_ms), 32'h0);
    chk("areset_ovf", 32'(overflow), 32'h0);
    #1 rst = 1'b0;
    repeat (3) cyc();
    chk("areset_wait", 32'(tick_ms), 32'h0);
    cyc();
    chk("areset_tick1", 32'(tick_ms), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom % 8) != 0;
      clr  = ($urandom % 64) == 0;
      hold = ($urandom % 10) < 2;
      if ($urandom % 8 == 0)
        mode = 2'($urandom % 4);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
